// File: rtl/periph_bus_bridge_pkg.sv
// Shared femto peripheral-bus constants, bridge defaults and slave index map.
package periph_bus_bridge_pkg;

   localparam int BUS_WIDTH     = 32;
   localparam int BUS_ACC_WIDTH = 2;
   localparam int CNT_W         = 16;

   localparam int BRG_NSLV    = 4;
   localparam int BRG_SELW    = 3;
   localparam int BRG_SEL_LO  = 12;
   localparam int BRG_TIMEOUT = 255;

   localparam logic [BRG_SELW-1:0] SLV_GPIO = 3'd0;
   localparam logic [BRG_SELW-1:0] SLV_TMR  = 3'd1;
   localparam logic [BRG_SELW-1:0] SLV_UART = 3'd2;
   localparam logic [BRG_SELW-1:0] SLV_SPI  = 3'd3;

   localparam logic [BUS_ACC_WIDTH-1:0] ACC_1B = 2'd0;
   localparam logic [BUS_ACC_WIDTH-1:0] ACC_2B = 2'd1;
   localparam logic [BUS_ACC_WIDTH-1:0] ACC_4B = 2'd2;

   // Busy bit: a single outstanding transaction at most.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } brg_state_e;

endpackage

// File: rtl/periph_bus_bridge_if.sv
// Bridge bus bundle: master-side request/response plus the shared slave fan-out.
interface periph_bus_bridge_if
   import periph_bus_bridge_pkg::*;
#(
   parameter int NSLV   = BRG_NSLV,
   parameter int SEL_LO = BRG_SEL_LO
);
   logic [BUS_WIDTH-1:0]      m_addr;
   logic                      m_w_rb;
   logic [BUS_ACC_WIDTH-1:0]  m_acc;
   logic [BUS_WIDTH-1:0]      m_wdata;
   logic                      m_req;
   logic [BUS_WIDTH-1:0]      m_rdata;
   logic                      m_resp;
   logic                      m_fault;

   logic [SEL_LO-1:0]         s_addr;
   logic                      s_w_rb;
   logic [BUS_ACC_WIDTH-1:0]  s_acc;
   logic [BUS_WIDTH-1:0]      s_wdata;
   logic [NSLV-1:0]           s_req;
   logic [NSLV*BUS_WIDTH-1:0] s_rdata;
   logic [NSLV-1:0]           s_resp;
   logic [NSLV-1:0]           s_fault;

   modport master (
      output m_addr, m_w_rb, m_acc, m_wdata, m_req,
      input  m_rdata, m_resp, m_fault
   );

   modport slave (
      input  m_addr, m_w_rb, m_acc, m_wdata, m_req,
      output m_rdata, m_resp, m_fault,
      output s_addr, s_w_rb, s_acc, s_wdata, s_req,
      input  s_rdata, s_resp, s_fault
   );
endinterface

// File: rtl/periph_bus_bridge_resp_mux.sv
// NSLV-way response/read-data select driven by the latched slave index.
module periph_bus_bridge_resp_mux
   import periph_bus_bridge_pkg::*;
#(
   parameter int NSLV = BRG_NSLV,
   parameter int SELW = BRG_SELW
)(
   input  logic [SELW-1:0]           i_idx,
   input  logic [NSLV*BUS_WIDTH-1:0] i_rdata,
   input  logic [NSLV-1:0]           i_resp,
   output logic                      o_resp,
   output logic [BUS_WIDTH-1:0]      o_rdata
);

   // AND-OR select so an out-of-range index yields no response
   always_comb begin
      logic w_hit;
      w_hit   = 1'b0;
      o_resp  = 1'b0;
      o_rdata = {BUS_WIDTH{1'b0}};
      for (int i = 0; i < NSLV; i++) begin
         w_hit   = (i_idx == SELW'(i));
         o_resp  = o_resp | (w_hit & i_resp[i]);
         o_rdata = o_rdata | ({BUS_WIDTH{w_hit}} & i_rdata[i*BUS_WIDTH +: BUS_WIDTH]);
      end
   end

endmodule

// File: rtl/periph_bus_bridge.sv
// Single-master to NSLV-slave router with outstanding-transaction tracking,
// hung-slave timeout and sticky {timeout, decode/overlap} error flags.
module periph_bus_bridge
   import periph_bus_bridge_pkg::*;
#(
   parameter int NSLV    = BRG_NSLV,
   parameter int SELW    = BRG_SELW,
   parameter int SEL_LO  = BRG_SEL_LO,
   parameter int TIMEOUT = BRG_TIMEOUT
)(
   input  logic              clk,
   input  logic              rstn,
   periph_bus_bridge_if.slave io_bus,
   output logic [1:0]        o_err
);

   localparam logic [SELW:0]      NSLV_LIM = (SELW+1)'(NSLV);
   localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

   brg_state_e            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [SELW-1:0]       r_idx;
   logic                  r_resp;
   logic [BUS_WIDTH-1:0]  r_rdata;
   logic [1:0]            r_err;

   brg_state_e            w_state_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [SELW-1:0]       w_idx_nxt;
   logic                  w_resp_nxt;
   logic [BUS_WIDTH-1:0]  w_rdata_nxt;
   logic [1:0]            w_err_nxt;

   logic [SELW-1:0]       w_sel;
   logic [BUS_WIDTH-1:0]  w_upper;
   logic                  w_bad;
   logic                  w_sel_fault;
   logic [NSLV-1:0]       w_onehot;
   logic                  w_req_go;
   logic                  w_m_fault;
   logic                  w_slv_resp;
   logic [BUS_WIDTH-1:0]  w_slv_rdata;

   assign w_sel   = io_bus.m_addr[SEL_LO+SELW-1:SEL_LO];
   assign w_upper = io_bus.m_addr >> (SEL_LO + SELW);
   assign w_bad   = ({1'b0, w_sel} >= NSLV_LIM) || (|w_upper);

   // Decoded one-hot target and that target's same-cycle fault
   always_comb begin
      w_onehot    = {NSLV{1'b0}};
      w_sel_fault = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         w_onehot[i] = (w_sel == SELW'(i));
         w_sel_fault = w_sel_fault | (w_onehot[i] & io_bus.s_fault[i]);
      end
   end

   periph_bus_bridge_resp_mux #(
      .NSLV (NSLV),
      .SELW (SELW)
   ) u_resp_mux (
      .i_idx   (r_idx),
      .i_rdata (io_bus.s_rdata),
      .i_resp  (io_bus.s_resp),
      .o_resp  (w_slv_resp),
      .o_rdata (w_slv_rdata)
   );

   // Next-state, request forwarding and fault decision
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_resp_nxt  = 1'b0;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
      w_req_go    = 1'b0;
      w_m_fault   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.m_req && w_bad) begin
               w_m_fault    = 1'b1;
               w_err_nxt[0] = 1'b1;
            end else if (io_bus.m_req) begin
               w_req_go = 1'b1;
               if (w_sel_fault) begin
                  w_m_fault = 1'b1;
               end else begin
                  w_idx_nxt   = w_sel;
                  w_cnt_nxt   = {CNT_W{1'b0}};
                  w_state_nxt = ST_WAIT;
               end
            end else begin
               w_req_go = 1'b0;
            end
         end
         ST_WAIT: begin
            // Overlapping request is rejected without touching the outstanding one
            if (io_bus.m_req) begin
               w_m_fault    = 1'b1;
               w_err_nxt[0] = 1'b1;
            end else begin
               w_m_fault = 1'b0;
            end
            if (w_slv_resp) begin
               w_resp_nxt  = 1'b1;
               w_rdata_nxt = w_slv_rdata;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt >= TMO_LAST) begin
               w_resp_nxt   = 1'b1;
               w_rdata_nxt  = {BUS_WIDTH{1'b0}};
               w_err_nxt[1] = 1'b1;
               w_state_nxt  = ST_IDLE;
            end else if (r_cnt != CNT_MAX) begin
               w_cnt_nxt = r_cnt + 16'd1;
            end else begin
               w_cnt_nxt = r_cnt;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and response registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_idx   <= {SELW{1'b0}};
         r_resp  <= 1'b0;
         r_rdata <= {BUS_WIDTH{1'b0}};
         r_err   <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_resp  <= w_resp_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign io_bus.s_addr  = io_bus.m_addr[SEL_LO-1:0];
   assign io_bus.s_w_rb  = io_bus.m_w_rb;
   assign io_bus.s_acc   = io_bus.m_acc;
   assign io_bus.s_wdata = io_bus.m_wdata;
   assign io_bus.s_req   = w_req_go ? w_onehot : {NSLV{1'b0}};

   assign io_bus.m_fault = w_m_fault;
   assign io_bus.m_resp  = r_resp;
   assign io_bus.m_rdata = r_rdata;
   assign o_err          = r_err;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Directed bench: stub slaves (reg, countdown timer, slow slave, hung slave) and a response scoreboard.
module tb_periph_bus_bridge;
   import periph_bus_bridge_pkg::*;

   logic       clk;
   logic       rstn;
   logic [1:0] err;

   typedef struct {
      bit          is_fault;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          pend[4];
   logic [31:0] pdata[4];
   logic [31:0] tmr_cnt;

   periph_bus_bridge_if #(.NSLV(4), .SEL_LO(12)) bus ();

   periph_bus_bridge #(
      .NSLV(4), .SELW(3), .SEL_LO(12), .TIMEOUT(8)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .io_bus (bus),
      .o_err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timer refuses byte accesses with a same-cycle fault
   assign bus.s_fault = {2'b00, bus.s_req[1] && (bus.s_acc == ACC_1B), 1'b0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic push(input bit f, input logic [31:0] d);
      exp_t e;
      e.is_fault = f;
      e.rdata    = d;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] acc,
                        input logic [31:0] wd, input logic [3:0] exp_sreq, input string nm);
      bus.m_addr  = a;
      bus.m_w_rb  = w;
      bus.m_acc   = acc;
      bus.m_wdata = wd;
      bus.m_req   = 1'b1;
      #2;
      chk({nm, "_sreq"}, {28'h0, bus.s_req}, {28'h0, exp_sreq});
      chk({nm, "_saddr"}, {20'h0, bus.s_addr}, {20'h0, a[11:0]});
      @(posedge clk); #1;
      bus.m_req = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Stub slaves: 0 = 1-cycle reg, 1 = 1-cycle countdown timer, 2 = 3-cycle, 3 = never answers
   initial begin
      logic [3:0]  seen;
      logic [3:0]  flt;
      logic [3:0]  rv;
      logic        wr;
      logic [11:0] off;
      logic [31:0] wd;
      bus.s_resp  = 4'b0000;
      bus.s_rdata = 128'h0;
      tmr_cnt     = 32'h0;
      for (int i = 0; i < 4; i++) begin pend[i] = 0; pdata[i] = 32'h0; end
      forever begin
         @(posedge clk);
         seen = bus.s_req; flt = bus.s_fault; wr = bus.s_w_rb; off = bus.s_addr; wd = bus.s_wdata;
         #1;
         rv = 4'b0000;
         if (seen[0]) begin pend[0] = 1; pdata[0] = 32'hC0DE_0000 | {20'h0, off}; end
         if (seen[1] && !flt[1]) begin pend[1] = 1; pdata[1] = wr ? wd : tmr_cnt; end
         if (seen[2]) begin pend[2] = 3; pdata[2] = 32'h2222_0000 | {20'h0, off}; end
         if (seen[1] && !flt[1] && wr) tmr_cnt = wd;
         else if (tmr_cnt != 32'h0) tmr_cnt = tmr_cnt - 32'h1;
         for (int i = 0; i < 4; i++) begin
            if (pend[i] != 0) begin
               pend[i]--;
               if (pend[i] == 0) begin
                  rv[i] = 1'b1;
                  bus.s_rdata[i*32 +: 32] = pdata[i];
               end
            end
         end
         bus.s_resp = rv;
      end
   end

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.m_fault === 1'b1 || bus.m_resp === 1'b1) begin
            chk("fault_resp_excl", {31'h0, bus.m_fault & bus.m_resp}, 32'h0);
            if (sb.size() == 0) begin
               chk("unexpected_evt", {30'h0, bus.m_fault, bus.m_resp}, 32'h0);
            end else begin
               e = sb.pop_front();
               chk("evt_kind", {31'h0, bus.m_fault}, {31'h0, e.is_fault});
               if (!e.is_fault) chk("m_rdata", bus.m_rdata, e.rdata);
            end
         end
      end
   end

   initial begin
      rstn = 1'b0;
      bus.m_addr = 32'h0; bus.m_w_rb = 1'b0; bus.m_acc = ACC_4B; bus.m_wdata = 32'h0; bus.m_req = 1'b0;
      cycles(3);
      rstn = 1'b1;
      chk("rst_err", {30'h0, err}, 32'h0);
      chk("rst_resp", {31'h0, bus.m_resp}, 32'h0);
      chk("rst_rdata", bus.m_rdata, 32'h0);

      // Timer write, then back-to-back reads showing the countdown
      push(1'b0, 32'h10);
      issue(32'h1000, 1'b1, ACC_4B, 32'h10, 4'b0010, "t1_wr");
      chk("t1_lat1", {31'h0, bus.m_resp}, 32'h0);
      cycles(1);
      chk("t1_lat2", {31'h0, bus.m_resp}, 32'h1);
      push(1'b0, 32'h0F);
      issue(32'h1000, 1'b0, ACC_4B, 32'h0, 4'b0010, "t1_rd1");
      cycles(1);
      push(1'b0, 32'h0D);
      issue(32'h1000, 1'b0, ACC_4B, 32'h0, 4'b0010, "t1_rd2");
      cycles(3);

      // Decode errors, then a good request proves the bridge stayed idle
      push(1'b1, 32'h0);
      issue(32'h5000, 1'b0, ACC_4B, 32'h0, 4'b0000, "t2_sel");
      chk("t2_err", {30'h0, err}, 32'h1);
      push(1'b1, 32'h0);
      issue(32'h8000_1000, 1'b0, ACC_4B, 32'h0, 4'b0000, "t2_hi");
      push(1'b0, 32'hC0DE_0008);
      issue(32'h0008, 1'b0, ACC_4B, 32'h0, 4'b0001, "t2_ok");
      cycles(3);

      // Slave fault, next request accepted immediately
      push(1'b1, 32'h0);
      issue(32'h1004, 1'b1, ACC_1B, 32'h55, 4'b0010, "t3_flt");
      push(1'b0, 32'hC0DE_0010);
      issue(32'h0010, 1'b0, ACC_4B, 32'h0, 4'b0001, "t3_nxt");
      cycles(3);

      // Overlap during a slow transaction
      issue(32'h2004, 1'b0, ACC_4B, 32'h0, 4'b0100, "t5_a");
      push(1'b1, 32'h0);
      issue(32'h0000, 1'b1, ACC_4B, 32'hDEAD, 4'b0000, "t5_ovl");
      push(1'b0, 32'h2222_0004);
      cycles(5);
      chk("t5_err", {30'h0, err}, 32'h1);

      // Reset while waiting: no response, stale slave response ignored
      issue(32'h2008, 1'b0, ACC_4B, 32'h0, 4'b0100, "t6_a");
      rstn = 1'b0;
      cycles(1);
      rstn = 1'b1;
      cycles(5);
      chk("t6_err", {30'h0, err}, 32'h0);
      chk("t6_resp", {31'h0, bus.m_resp}, 32'h0);

      // Hung slave, forced completion at cycle 9
      push(1'b0, 32'h0);
      issue(32'h3000, 1'b0, ACC_4B, 32'h0, 4'b1000, "t4_hung");
      cycles(7);
      chk("t4_early", {31'h0, bus.m_resp}, 32'h0);
      cycles(1);
      chk("t4_resp", {31'h0, bus.m_resp}, 32'h1);
      chk("t4_err", {30'h0, err}, 32'h2);
      cycles(3);

      chk("sb_drain", sb.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
